// File: rtl/fpu_issue_ctrl.sv
// FP issue sequencer: registers one op for the FPU, pulses divide start, buffers one result.
// Latency: single-cycle ops are valid 2 cycles after accept, DIV at least 4; out_ready only in IDLE, result held until in_wb_ready.
module fpu_issue_ctrl #(
  parameter int          RD_W        = 5,
  parameter int          DIV_TIMEOUT = 64,
  parameter logic [31:0] QNAN        = 32'h7FC00000
) (
  input  logic            in_Clk,
  input  logic            in_Rst,
  input  logic            in_valid,
  output logic            out_ready,
  input  logic [4:0]      in_op,
  input  logic [31:0]     in_a,
  input  logic [31:0]     in_b,
  input  logic [RD_W-1:0] in_rd,
  input  logic            in_flush,
  output logic [4:0]      out_FPU_Op,
  output logic [31:0]     out_rs1,
  output logic [31:0]     out_rs2,
  output logic            out_start,
  input  logic [31:0]     in_fpu_data,
  input  logic            in_fpu_stall,
  output logic            out_wb_valid,
  input  logic            in_wb_ready,
  output logic [31:0]     out_wb_data,
  output logic [RD_W-1:0] out_wb_rd,
  output logic            out_wb_to_int,
  output logic            out_wb_exc
);

  localparam int CW = $clog2(DIV_TIMEOUT + 2);

  typedef enum logic [2:0] {IDLE, EXEC, DIV_START, DIV_WAIT, RESULT, DRAIN} state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [4:0]        op_q;
  logic [31:0]       rs1_q, rs2_q, wb_data_q;
  logic [RD_W-1:0]   rd_q, wb_rd_q;
  logic              ready_q, start_q, wb_valid_q, wb_to_int_q, wb_exc_q;
  logic              timeout;

  function automatic logic is_unsup(input logic [4:0] op);
    return (op == 5'b00100) || (op == 5'b01011) || (op == 5'b10011) || (op >= 5'b10110);
  endfunction

  function automatic logic is_int(input logic [4:0] op);
    return op inside {5'b01000, 5'b01001, 5'b01010, 5'b01100, 5'b01101, 5'b10000, 5'b10010};
  endfunction

  assign cnt_d   = cnt_q + CW'(1);
  assign timeout = (cnt_d >= CW'(DIV_TIMEOUT));

  always_ff @(posedge in_Clk) begin
    if (in_Rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      ready_q     <= 1'b1;
      start_q     <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_data_q   <= '0;
      wb_rd_q     <= '0;
      wb_to_int_q <= 1'b0;
      wb_exc_q    <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid && !in_flush) begin
            op_q    <= in_op;
            rs1_q   <= in_a;
            rs2_q   <= in_b;
            rd_q    <= in_rd;
            ready_q <= 1'b0;
            if (in_op == 5'b00011) begin
              state_q <= DIV_START;
              start_q <= 1'b1;
            end else begin
              state_q <= EXEC;
            end
          end
        end
        EXEC: begin
          if (in_flush) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end else begin
            wb_data_q   <= is_unsup(op_q) ? QNAN : in_fpu_data;
            wb_exc_q    <= is_unsup(op_q);
            wb_to_int_q <= is_int(op_q);
            wb_rd_q     <= rd_q;
            wb_valid_q  <= 1'b1;
            state_q     <= RESULT;
          end
        end
        DIV_START: begin
          cnt_q <= '0;
          if (in_flush) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end else begin
            state_q <= DIV_WAIT;
          end
        end
        DIV_WAIT: begin
          cnt_q <= cnt_d;
          // Stall is not yet meaningful on the first wait cycle (cnt_q == 0).
          if (in_flush) begin
            state_q <= DRAIN;
          end else if ((cnt_q != '0 && !in_fpu_stall) || timeout) begin
            wb_data_q   <= (cnt_q != '0 && !in_fpu_stall) ? in_fpu_data : QNAN;
            wb_exc_q    <= !(cnt_q != '0 && !in_fpu_stall);
            wb_to_int_q <= is_int(op_q);
            wb_rd_q     <= rd_q;
            wb_valid_q  <= 1'b1;
            state_q     <= RESULT;
          end
        end
        RESULT: begin
          if (in_flush || in_wb_ready) begin
            wb_valid_q <= 1'b0;
            ready_q    <= 1'b1;
            state_q    <= IDLE;
          end
        end
        DRAIN: begin
          cnt_q <= cnt_d;
          if (!in_fpu_stall || timeout) begin
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign out_ready     = ready_q;
  assign out_FPU_Op    = op_q;
  assign out_rs1       = rs1_q;
  assign out_rs2       = rs2_q;
  assign out_start     = start_q;
  assign out_wb_valid  = wb_valid_q;
  assign out_wb_data   = wb_data_q;
  assign out_wb_rd     = wb_rd_q;
  assign out_wb_to_int = wb_to_int_q;
  assign out_wb_exc    = wb_exc_q;

endmodule
